// File: rtl/adsr_pkg.sv
// adsr_pkg: shared definitions for the ADSR voice scheduler slice.
//   - Default voice count and select width.
//   - MIDI note width.
//   - Scan FSM state encoding, used by adsr_voice_scheduler.
package adsr_pkg;

  localparam int unsigned VOICES_DEF = 8;
  localparam int unsigned VBITS_DEF  = 3;
  localparam int unsigned NOTE_W     = 7;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RUN    = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } scan_state_t;

endpackage

// File: rtl/voice_alloc.sv
// voice_alloc: holds the per-voice gate and note number and allocates voices
// from note-on/note-off events.
//   clk, rst_n        clock, synchronous active-low reset
//   note_on, note_off single-cycle event strobes qualified by note
//   note              MIDI note number
//   voice_gate        per-voice gate vector
//   voice_note        per-voice note, voice v at [7v+6:7v]
//   drop              one-cycle pulse when a note_on found no free voice
// Optional: ADSR_VOICE_STEAL_EN makes a note_on with every voice gated take
// over the voice at a round-robin steal pointer instead of being discarded.
module voice_alloc
  import adsr_pkg::*;
#(
  parameter int unsigned VOICES = VOICES_DEF,
  parameter int unsigned VBITS  = VBITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     note_on,
  input  logic                     note_off,
  input  logic [NOTE_W-1:0]        note,
  output logic [VOICES-1:0]        voice_gate,
  output logic [NOTE_W*VOICES-1:0] voice_note,
  output logic                     drop
);

  logic [NOTE_W-1:0] notes [VOICES];
  logic [VOICES-1:0] gates;
  logic [VOICES-1:0] gate_off;
  logic              hit;
  logic              free_found;
  logic [VBITS-1:0]  free_idx;
`ifdef ADSR_VOICE_STEAL_EN
  logic [VBITS-1:0]  steal_ptr;
`endif

  // note_off is resolved first; retrigger match and free search both look at
  // the post-note_off gates, so an on/off pair on the same note reallocates.
  always_comb begin
    gate_off   = gates;
    hit        = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned v = 0; v < VOICES; v++) begin
      if (note_off && gates[v] && (notes[v] == note))
        gate_off[v] = 1'b0;
      if (gate_off[v] && (notes[v] == note))
        hit = 1'b1;
      if (!gate_off[v] && !free_found) begin
        free_found = 1'b1;
        free_idx   = VBITS'(v);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gates <= '0;
      drop  <= 1'b0;
      for (int unsigned v = 0; v < VOICES; v++)
        notes[v] <= '0;
`ifdef ADSR_VOICE_STEAL_EN
      steal_ptr <= '0;
`endif
    end else begin
      gates <= gate_off;
      drop  <= 1'b0;
      if (note_on && !hit) begin
        if (free_found) begin
          gates[free_idx] <= 1'b1;
          notes[free_idx] <= note;
`ifdef ADSR_VOICE_STEAL_EN
          steal_ptr <= steal_ptr + VBITS'(1);
`endif
        end else begin
`ifdef ADSR_VOICE_STEAL_EN
          notes[steal_ptr] <= note;
          steal_ptr        <= steal_ptr + VBITS'(1);
`endif
          drop <= 1'b1;
        end
      end
    end
  end

  assign voice_gate = gates;

  for (genvar v = 0; v < VOICES; v++) begin : g_pack
    assign voice_note[v*NOTE_W +: NOTE_W] = notes[v];
  end

endmodule

// File: rtl/adsr_voice_scheduler.sv
// adsr_voice_scheduler: per sample frame, walks every voice slot of the
// RAM-based ADSR envelope engine (settle, ena0, ena1 per slot) and allocates
// voices from note events.
//   clk, rst_n        clock, synchronous active-low reset
//   note_on, note_off single-cycle note event strobes; note qualifies them
//   sel               voice index to the envelope engine
//   ena0, ena1        envelope state-machine / write-back enables
//   gate              gate of voice sel
//   voice_gate        per-voice gate vector
//   voice_note        per-voice note, voice v at [7v+6:7v]
//   frame_done        one-cycle pulse after the last voice's ena1
//   drop              one-cycle pulse when a note_on found no free voice
// Optional: define ADSR_VOICE_STEAL_EN to enable voice stealing in voice_alloc.
module adsr_voice_scheduler
  import adsr_pkg::*;
#(
  parameter int unsigned VOICES   = VOICES_DEF,
  parameter int unsigned VBITS    = VBITS_DEF,
  parameter int unsigned TICK_DIV = 1562
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     note_on,
  input  logic                     note_off,
  input  logic [6:0]               note,
  output logic [VBITS-1:0]         sel,
  output logic                     ena0,
  output logic                     ena1,
  output logic                     gate,
  output logic [VOICES-1:0]        voice_gate,
  output logic [7*VOICES-1:0]      voice_note,
  output logic                     frame_done,
  output logic                     drop
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);

  logic [DIV_W-1:0] div;
  logic             tick;
  scan_state_t      state, state_nx;
  logic [VBITS-1:0] sel_nx;

  assign tick = (div == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)
      div <= '0;
    else if (tick)
      div <= '0;
    else
      div <= div + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_WAIT;
      sel   <= '0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
    end
  end

  // SETTLE gives the envelope RAM one cycle to read slot sel before ena0.
  always_comb begin
    state_nx   = state;
    sel_nx     = sel;
    ena0       = 1'b0;
    ena1       = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      ST_WAIT: begin
        if (tick) begin
          sel_nx   = '0;
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: state_nx = ST_RUN;
      ST_RUN: begin
        ena0     = 1'b1;
        state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        ena1 = 1'b1;
        if (sel == VBITS'(VOICES - 1)) begin
          state_nx = ST_DONE;
        end else begin
          sel_nx   = sel + VBITS'(1);
          state_nx = ST_SETTLE;
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        sel_nx     = '0;
        state_nx   = ST_WAIT;
      end
      default: state_nx = ST_WAIT;
    endcase
  end

  voice_alloc #(
    .VOICES (VOICES),
    .VBITS  (VBITS)
  ) u_alloc (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_on    (note_on),
    .note_off   (note_off),
    .note       (note),
    .voice_gate (voice_gate),
    .voice_note (voice_note),
    .drop       (drop)
  );

  assign gate = voice_gate[sel];

endmodule

// File: tb/tb_adsr_voice_scheduler.sv
// Testbench for adsr_voice_scheduler with TICK_DIV=64. Scan outputs are
// checked every cycle against a frame-phase model; note events push expected
// voice state onto a queue that is popped when the DUT result is due.
module tb_adsr_voice_scheduler;

  localparam int TD = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        note_on = 1'b0;
  logic        note_off = 1'b0;
  logic [6:0]  note = '0;
  logic [2:0]  sel;
  logic        ena0, ena1, gate, frame_done, drop;
  logic [7:0]  voice_gate;
  logic [55:0] voice_note;

  always #5 clk = ~clk;

  adsr_voice_scheduler #(
    .VOICES   (8),
    .VBITS    (3),
    .TICK_DIV (TD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_on    (note_on),
    .note_off   (note_off),
    .note       (note),
    .sel        (sel),
    .ena0       (ena0),
    .ena1       (ena1),
    .gate       (gate),
    .voice_gate (voice_gate),
    .voice_note (voice_note),
    .frame_done (frame_done),
    .drop       (drop)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  typedef struct {
    int          due;
    string       tag;
    logic [7:0]  g;
    logic [55:0] n;
    logic        d;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  m_gate  = '0;
  logic [55:0] m_notes = '0;
  int          m_ptr   = 0;
  int          cyc     = 0;
  int          m_div   = 0;
  int          m_ph    = 0;

  // Frame model: phase 0 idle, 1..24 settle/run/write per voice, 25 done.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_div <= 0;
      m_ph  <= 0;
    end else begin
      if (m_ph != 0) m_ph <= (m_ph == 25) ? 0 : m_ph + 1;
      else if (m_div == TD - 1) m_ph <= 1;
      m_div <= (m_div == TD - 1) ? 0 : m_div + 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   es;
    logic e0, e1, efd;
    if (cyc >= 1) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check({e.tag, "_gate"}, voice_gate, e.g);
        check({e.tag, "_note"}, voice_note, e.n);
        check({e.tag, "_drop"}, drop, e.d);
        m_gate  = e.g;
        m_notes = e.n;
      end
      es = 0; e0 = 1'b0; e1 = 1'b0; efd = 1'b0;
      if (m_ph >= 1 && m_ph <= 24) begin
        es = (m_ph - 1) / 3;
        e0 = ((m_ph - 1) % 3) == 1;
        e1 = ((m_ph - 1) % 3) == 2;
      end else if (m_ph == 25) begin
        es  = 7;
        efd = 1'b1;
      end
      check("sel", sel, es);
      check("ena0", ena0, e0);
      check("ena1", ena1, e1);
      check("frame_done", frame_done, efd);
      check("gate", gate, m_gate[es]);
    end
  end

  task automatic ev(input logic on, input logic off, input logic [6:0] n, input string tag);
    logic [7:0]  g;
    logic [55:0] nn;
    logic        d;
    logic        hit;
    int          fi;
    @(negedge clk);
    g = m_gate; nn = m_notes; d = 1'b0; hit = 1'b0; fi = -1;
    if (off)
      for (int v = 0; v < 8; v++)
        if (g[v] && nn[v*7 +: 7] == n) g[v] = 1'b0;
    if (on) begin
      for (int v = 0; v < 8; v++)
        if (g[v] && nn[v*7 +: 7] == n) hit = 1'b1;
      if (!hit) begin
        for (int v = 0; v < 8; v++)
          if (!g[v] && fi < 0) fi = v;
        if (fi >= 0) begin
          g[fi] = 1'b1;
          nn[fi*7 +: 7] = n;
          m_ptr = (m_ptr + 1) % 8;
        end else begin
`ifdef ADSR_VOICE_STEAL_EN
          nn[m_ptr*7 +: 7] = n;
          m_ptr = (m_ptr + 1) % 8;
`endif
          d = 1'b1;
        end
      end
    end
    note_on = on; note_off = off; note = n;
    q.push_back('{cyc + 1, tag, g, nn, d});
    q.push_back('{cyc + 2, {tag, "_hold"}, g, nn, 1'b0});
    @(negedge clk);
    note_on = 1'b0; note_off = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    m_ptr = 0;
    q.push_back('{cyc + 1, tag, 8'h00, 56'h0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    check("rst_sel", sel, 0);
    check("rst_ena0", ena0, 0);
    check("rst_ena1", ena1, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_drop", drop, 0);
    check("rst_voice_gate", voice_gate, 0);
    check("rst_voice_note", voice_note, 0);
    rst_n = 1'b1;

    repeat (140) @(negedge clk);

    ev(1'b1, 1'b0, 7'd60, "on60");
    ev(1'b1, 1'b0, 7'd64, "on64");
    repeat (70) @(negedge clk);
    ev(1'b0, 1'b1, 7'd60, "off60");
    ev(1'b1, 1'b0, 7'd67, "on67");
    ev(1'b1, 1'b0, 7'd72, "on72");
    ev(1'b1, 1'b1, 7'd72, "onoff72");
    ev(1'b0, 1'b1, 7'd99, "off_nomatch");
    repeat (70) @(negedge clk);

    do_reset("clr");
    for (int i = 0; i < 8; i++) ev(1'b1, 1'b0, 7'(40 + i), "fill");
    ev(1'b1, 1'b0, 7'd50, "full50");
    ev(1'b1, 1'b0, 7'd51, "full51");
    ev(1'b1, 1'b0, 7'd45, "retrig45");
    repeat (70) @(negedge clk);

    w = 0;
    while (!(ena0 && sel == 3'd3) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("mid_frame_wait", {ena0, sel}, {1'b1, 3'd3});
    do_reset("mid_reset");
    repeat (100) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
